bcd_conv_arbiter: RTL and testbench

- Shares one iterative binary-to-BCD (shift-add-3) engine among NUM_REQ requesters, e.g. display drivers, UART print formatter and debug counters.
- Round-robin arbitration, a valid/ready request port per requester, and a single valid/ready response port tagged with the requester ID.
- Sits between the measurement/counter logic and the seven-segment and text output paths.
- Replaces per-client free-running converters, which have no start/done handshake.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_dabble_core.sv | 73 +++++++
 rtl/bcd_conv_arbiter.sv | 129 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion arbiter.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Largest value representable in the given number of decimal digits.
   function automatic longint unsigned pow10_minus1(input int digits);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < digits; i++) p = p * 10;
      return p - 1;
   endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative shift-add-3 binary-to-BCD core; the start edge performs the first of DATA_W iterations.
module bcd_dabble_core
   import bcd_pkg::*;
#(
   parameter int DATA_W = 27,
   parameter int DIGITS = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [DATA_W-1:0]               bin,
   output logic                            busy,
   output logic                            done,
   output logic [DIGITS*BCD_DIGIT_W-1:0]   bcd
);

   localparam int BCD_W = DIGITS * BCD_DIGIT_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic [BCD_W-1:0]  bcd_src;
   logic [BCD_W-1:0]  bcd_adj;
   logic [BCD_W-1:0]  bcd_next;
   logic              bit_in;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int d = 0; d < DIGITS; d++) begin
         if (v[d*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd4)
            r[d*BCD_DIGIT_W +: BCD_DIGIT_W] = v[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
      return r;
   endfunction

   // A fresh start iterates on an empty register so no extra load cycle is spent.
   always_comb begin
      bcd_src  = start ? '0 : bcd;
      bit_in   = start ? bin[DATA_W-1] : shreg[DATA_W-1];
      bcd_adj  = add3(bcd_src);
      bcd_next = {bcd_adj[BCD_W-2:0], bit_in};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
         cnt   <= '0;
         bcd   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (start) begin
         bcd   <= bcd_next;
         shreg <= {bin[DATA_W-2:0], 1'b0};
         cnt   <= CNT_W'(1);
         busy  <= 1'b1;
         done  <= 1'b0;
      end else if (busy) begin
         bcd   <= bcd_next;
         shreg <= {shreg[DATA_W-2:0], 1'b0};
         cnt   <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(DATA_W - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end else begin
            done <= 1'b0;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one BCD core among NUM_REQ requesters.
// Optional BCD_OVF_SAT_EN: saturate to all 9s and flag rsp_ovf when the operand exceeds 10^DIGITS-1.
module bcd_conv_arbiter
   import bcd_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 27,
   parameter int DIGITS  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]         req_data,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
   output logic [DIGITS*BCD_DIGIT_W-1:0]     rsp_bcd,
   output logic                              rsp_ovf
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int BCD_W = DIGITS * BCD_DIGIT_W;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   cur_id;
   logic              cur_ovf;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [DATA_W-1:0] gnt_data;
   logic              accept;
   logic              ovf_now;
   logic              core_busy;
   logic              core_done;
   logic [BCD_W-1:0]  core_bcd;
   int                idx;

`ifdef BCD_OVF_SAT_EN
   localparam longint unsigned MAX_VAL = pow10_minus1(DIGITS);

   function automatic logic is_ovf(input logic [DATA_W-1:0] op);
      return 64'(op) > MAX_VAL;
   endfunction
`endif

   function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] v, input logic ovf);
      return ovf ? {DIGITS{4'h9}} : v;
   endfunction

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_data  = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(idx);
            gnt_data  = req_data[idx*DATA_W +: DATA_W];
         end
      end
   end

   assign accept    = (state == IDLE) && gnt_found && !core_busy;
   assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

`ifdef BCD_OVF_SAT_EN
   assign ovf_now = is_ovf(gnt_data);
`else
   assign ovf_now = 1'b0;
`endif

   bcd_dabble_core #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (gnt_data),
      .busy  (core_busy),
      .done  (core_done),
      .bcd   (core_bcd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         cur_ovf   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_bcd   <= '0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cur_id  <= gnt_idx;
                  cur_ovf <= ovf_now;
                  rr_ptr  <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               if (core_done) begin
                  rsp_bcd   <= sat_bcd(core_bcd, cur_ovf);
                  rsp_id    <= cur_id;
                  rsp_ovf   <= cur_ovf;
                  rsp_valid <= 1'b1;
                  state     <= RESPOND;
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: arbitration model, decimal reference, latency and hold checks.
module tb_bcd_conv_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 27;
   localparam int DG  = 8;
   localparam int LAT = DW + 1;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] bcd;
      logic        ovf;
      logic [31:0] acc_cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_bcd;
   logic            rsp_ovf;

   exp_t        sb[$];
   int          ord[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          tb_rr = 0;
   int          svc_cnt = 0;
   bit          tb_busy = 0;
   bit          rsp_seen = 0;
   bit          stalled = 0;
   logic [NR-1:0] hold_mask = '0;
   logic [1:0]  prev_id;
   logic [31:0] prev_bcd;
   logic        prev_ovf;

   bcd_conv_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DIGITS(DG)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_bcd   (rsp_bcd),
      .rsp_ovf   (rsp_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Reference conversion by repeated division: {ovf, bcd}.
   function automatic logic [32:0] ref_conv(input longint unsigned v);
      logic [31:0] r;
      longint unsigned p;
      logic ovf;
      r = '0;
      p = 1;
      for (int d = 0; d < DG; d++) begin
         r[d*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      ovf = 1'b0;
`ifdef BCD_OVF_SAT_EN
      if (v > 64'd99999999) begin
         ovf = 1'b1;
         r   = 32'h99999999;
      end
`endif
      return {ovf, r};
   endfunction

   task automatic set_req(input int i, input logic [DW-1:0] d);
      req_data[i*DW +: DW] = d;
      req_valid[i] = 1'b1;
   endtask

   task automatic step();
      int   g;
      int   ix;
      bit   acc;
      exp_t e;
      logic [32:0] m;
      acc = 0;
      g = -1;
      #1;
      if (!rst) begin
         chk("rst_valid", rsp_valid, 0);
         chk("rst_bcd", rsp_bcd, 0);
      end else if (!tb_busy) begin
         chk("rsp_idle", rsp_valid, 0);
         for (int k = 0; k < NR; k++) begin
            ix = (tb_rr + k) % NR;
            if (g < 0 && req_valid[ix]) g = ix;
         end
         if (g >= 0) begin
            chk($sformatf("grant%0d", g), req_ready, 64'(1 << g));
            m = ref_conv(64'(req_data[g*DW +: DW]));
            e.id = 2'(g);
            e.bcd = m[31:0];
            e.ovf = m[32];
            e.acc_cyc = 32'(cyc);
            sb.push_back(e);
            tb_rr = (g + 1) % NR;
            tb_busy = 1;
            svc_cnt++;
            acc = 1;
         end else begin
            chk("ready_none", req_ready, 0);
         end
      end else begin
         chk("ready_busy", req_ready, 0);
         if (rsp_valid) begin
            if (!rsp_seen) begin
               rsp_seen = 1;
               if (sb.size() == 0) chk("spurious_rsp", 1, 0);
               else chk("latency", 64'(cyc - int'(sb[0].acc_cyc)), LAT);
            end
            if (stalled) begin
               chk("hold_id", rsp_id, prev_id);
               chk("hold_bcd", rsp_bcd, prev_bcd);
               chk("hold_ovf", rsp_ovf, prev_ovf);
            end
            prev_id = rsp_id;
            prev_bcd = rsp_bcd;
            prev_ovf = rsp_ovf;
            stalled = !rsp_ready;
            if (rsp_ready) begin
               if (sb.size() == 0) begin
                  chk("sb_empty", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", rsp_id, e.id);
                  chk("rsp_bcd", rsp_bcd, e.bcd);
                  chk("rsp_ovf", rsp_ovf, e.ovf);
               end
               ord.push_back(int'(rsp_id));
               tb_busy = 0;
               rsp_seen = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc && !hold_mask[g]) req_valid[g] = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while ((tb_busy || req_valid != 0) && n < max) begin
         step();
         n++;
      end
      if (n >= max) chk("timeout", 1, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req_valid = '0;
      sb.delete();
      tb_busy = 0;
      tb_rr = 0;
      rsp_seen = 0;
      stalled = 0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      int n;
      int s0;
      rst = 1'b0;
      req_valid = '0;
      req_data = '0;
      rsp_ready = 1'b1;
      step();
      chk("rst_id", rsp_id, 0);
      chk("rst_ovf", rsp_ovf, 0);
      chk("rst_ready", req_ready, 0);
      rst = 1'b1;
      step();

      // single request
      set_req(0, 27'd12345678);
      wait_idle(100);

      // all four together from reset, strict rotation
      do_reset();
      ord.delete();
      set_req(0, 27'd1);
      set_req(1, 27'd22);
      set_req(2, 27'd333);
      set_req(3, 27'd4444);
      wait_idle(300);
      chk("order_n", ord.size(), 4);
      for (int i = 0; i < 4 && i < ord.size(); i++) chk($sformatf("order%0d", i), ord[i], i);

      // backpressure with a competing request pending
      rsp_ready = 1'b0;
      set_req(2, 27'd99999999);
      n = 0;
      while (!(tb_busy && rsp_valid) && n < 60) begin
         step();
         n++;
      end
      set_req(0, 27'd42);
      for (int i = 0; i < 10; i++) step();
      rsp_ready = 1'b1;
      wait_idle(200);

      // boundaries
      set_req(1, 27'd0);
      wait_idle(100);
      set_req(1, 27'd99999999);
      wait_idle(100);
      set_req(1, 27'd134217727);
      wait_idle(100);

      // reset during conversion; requester 1 served first so rr would point at 2
      set_req(1, 27'd555);
      step();
      for (int i = 0; i < 10; i++) step();
      do_reset();
      for (int i = 0; i < 40; i++) step();
      set_req(1, 27'd9876543);
      set_req(3, 27'd1234);
      wait_idle(200);
      chk("post_rst_first", ord[ord.size()-2], 1);

      // fairness: requester 1 always valid, requester 3 pulses
      hold_mask = 4'b0010;
      set_req(1, 27'd7);
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 5; i++) step();
         s0 = svc_cnt;
         set_req(3, 27'(1000 + p));
         n = 0;
         while (req_valid[3] && n < 200) begin
            step();
            n++;
         end
         chk("fair_wait", (svc_cnt - s0) <= 2, 1);
      end
      hold_mask = '0;
      wait_idle(200);

      // random operands on random requesters
      for (int i = 0; i < 6; i++) begin
         set_req(int'($urandom_range(0, NR-1)), 27'($urandom_range(0, 134217727)));
         wait_idle(100);
      end

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
